rx_pkt_router: RTL and testbench

RX_PKT_ROUTER -- requirements
Module: rx_pkt_router

---
 rtl/rx_pkt_router.sv | 164 ++++++++++++++++
 tb/tb_rx_pkt_router.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_router.sv
// Splits framed FIFO words into TLP beats and DLLP words, one FIFO read in flight at a time.
// Optional drop counting is compiled in when RX_ROUTER_DROPCNT_EN is defined.
module rx_pkt_router #(
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic         pclk,
  input  logic         reset,
  input  logic         fifo_empty,
  output logic         fifo_rd,
  input  logic [511:0] data_in,
  input  logic [63:0]  stp_in,
  input  logic [63:0]  sdp_in,
  input  logic [63:0]  end_in,
  input  logic [63:0]  valid_in,
  input  logic [79:0]  length_in,
  output logic [511:0] tlp_data,
  output logic [63:0]  tlp_be,
  output logic [79:0]  tlp_len,
  output logic         tlp_sop,
  output logic         tlp_eop,
  output logic         tlp_err,
  output logic         tlp_valid,
  input  logic         tlp_ready,
  output logic [511:0] dllp_data,
  output logic [63:0]  dllp_be,
  output logic         dllp_valid,
  input  logic         dllp_ready,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned CntW = $clog2(MAX_WORDS + 1) + 1;

  typedef enum logic [2:0] {StIdle, StRdWait, StRoute, StHoldTlp, StHoldDllp} state_t;

  state_t          state;
  logic [511:0]    cap_data;
  logic [63:0]     cap_stp, cap_sdp, cap_end, cap_valid;
  logic [79:0]     cap_len;
  logic            tlp_open;
  logic [CntW-1:0] word_cnt;
  logic            drop_word;

  // Non-empty word outside a TLP that is neither a TLP start nor a complete DLLP.
  assign drop_word = (state == StRoute) && (cap_valid != '0) && !tlp_open && !cap_stp[0] &&
                     !(cap_sdp[0] && (|cap_end));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      fifo_rd    <= 1'b0;
      cap_data   <= '0;
      cap_stp    <= '0;
      cap_sdp    <= '0;
      cap_end    <= '0;
      cap_valid  <= '0;
      cap_len    <= '0;
      tlp_open   <= 1'b0;
      word_cnt   <= '0;
      tlp_data   <= '0;
      tlp_be     <= '0;
      tlp_len    <= '0;
      tlp_sop    <= 1'b0;
      tlp_eop    <= 1'b0;
      tlp_err    <= 1'b0;
      tlp_valid  <= 1'b0;
      dllp_data  <= '0;
      dllp_be    <= '0;
      dllp_valid <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        StIdle: begin
          if (!fifo_empty) begin
            fifo_rd <= 1'b1;
            state   <= StRdWait;
          end
        end
        StRdWait: begin
          cap_data  <= data_in;
          cap_stp   <= stp_in;
          cap_sdp   <= sdp_in;
          cap_end   <= end_in;
          cap_valid <= valid_in;
          cap_len   <= length_in;
          state     <= StRoute;
        end
        StRoute: begin
          if (cap_valid == '0 || drop_word) begin
            state <= StIdle;
          end else if (tlp_open) begin
            tlp_data  <= cap_data;
            tlp_be    <= cap_valid;
            tlp_sop   <= 1'b0;
            tlp_valid <= 1'b1;
            state     <= StHoldTlp;
            // A stray start marker aborts the open TLP; the word is never re-parsed.
            if ((|cap_stp) || (|cap_sdp)) begin
              tlp_eop  <= 1'b1;
              tlp_err  <= 1'b1;
              tlp_open <= 1'b0;
              word_cnt <= '0;
            end else if (|cap_end) begin
              tlp_eop  <= 1'b1;
              tlp_err  <= 1'b0;
              tlp_open <= 1'b0;
              word_cnt <= '0;
            end else if (word_cnt == CntW'(MAX_WORDS)) begin
              tlp_eop  <= 1'b1;
              tlp_err  <= 1'b1;
              tlp_open <= 1'b0;
              word_cnt <= '0;
            end else begin
              tlp_eop  <= 1'b0;
              tlp_err  <= 1'b0;
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (cap_stp[0]) begin
            tlp_data  <= cap_data;
            tlp_be    <= cap_valid;
            tlp_len   <= cap_len;
            tlp_sop   <= 1'b1;
            tlp_eop   <= |cap_end;
            tlp_err   <= 1'b0;
            tlp_valid <= 1'b1;
            tlp_open  <= ~(|cap_end);
            word_cnt  <= (|cap_end) ? '0 : CntW'(1);
            state     <= StHoldTlp;
          end else begin
            dllp_data  <= cap_data;
            dllp_be    <= cap_valid;
            dllp_valid <= 1'b1;
            state      <= StHoldDllp;
          end
        end
        StHoldTlp: begin
          if (tlp_ready) begin
            tlp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        StHoldDllp: begin
          if (dllp_ready) begin
            dllp_valid <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef RX_ROUTER_DROPCNT_EN
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_word && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_pkt_router.sv
// Directed table-driven bench for rx_pkt_router, plus hand-written hold and reset sequences.
module tb_rx_pkt_router;

  logic         pclk = 1'b0;
  logic         reset;
  logic         fifo_empty;
  logic         fifo_rd;
  logic [511:0] data_in;
  logic [63:0]  stp_in, sdp_in, end_in, valid_in;
  logic [79:0]  length_in;
  logic [511:0] tlp_data;
  logic [63:0]  tlp_be;
  logic [79:0]  tlp_len;
  logic         tlp_sop, tlp_eop, tlp_err, tlp_valid, tlp_ready;
  logic [511:0] dllp_data;
  logic [63:0]  dllp_be;
  logic         dllp_valid, dllp_ready;
  logic [15:0]  drop_cnt;

  rx_pkt_router #(.MAX_WORDS(8)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .data_in    (data_in),
    .stp_in     (stp_in),
    .sdp_in     (sdp_in),
    .end_in     (end_in),
    .valid_in   (valid_in),
    .length_in  (length_in),
    .tlp_data   (tlp_data),
    .tlp_be     (tlp_be),
    .tlp_len    (tlp_len),
    .tlp_sop    (tlp_sop),
    .tlp_eop    (tlp_eop),
    .tlp_err    (tlp_err),
    .tlp_valid  (tlp_valid),
    .tlp_ready  (tlp_ready),
    .dllp_data  (dllp_data),
    .dllp_be    (dllp_be),
    .dllp_valid (dllp_valid),
    .dllp_ready (dllp_ready),
    .drop_cnt   (drop_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [63:0] stp;
    logic [63:0] sdp;
    logic [63:0] endm;
    logic [63:0] vld;
    logic [79:0] len;
    bit          tlp;
    bit          dllp;
    bit          sop;
    bit          eop;
    bit          err;
    logic [79:0] elen;
    int          hold;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] stp, input logic [63:0] sdp,
                              input logic [63:0] endm, input logic [63:0] vld,
                              input logic [79:0] len, input bit tlp, input bit dllp,
                              input bit sop, input bit eop, input bit err,
                              input logic [79:0] elen, input int hold);
    vec_t v;
    v.stp = stp; v.sdp = sdp; v.endm = endm; v.vld = vld; v.len = len;
    v.tlp = tlp; v.dllp = dllp; v.sop = sop; v.eop = eop; v.err = err;
    v.elen = elen; v.hold = hold;
    return v;
  endfunction

  task automatic check_drops(input string name);
`ifdef RX_ROUTER_DROPCNT_EN
    check(name, drop_cnt, exp_drop);
`else
    check(name, drop_cnt, 0);
`endif
  endtask

  task automatic clear_inputs();
    data_in = '0; stp_in = '0; sdp_in = '0; end_in = '0; valid_in = '0; length_in = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [63:0]  w;
    logic [511:0] d;
    int           t;
    w = 64'hD00D_0000_0000_1000 + 64'(idx);
    d = {8{w}};
    tlp_ready  = (v.hold == 0);
    dllp_ready = (v.hold == 0);
    fifo_empty = 1'b0;
    t = 0;
    while (!fifo_rd && t < 10) begin
      @(negedge pclk);
      t++;
    end
    check("fifo_rd_seen", fifo_rd, 1'b1);
    if (!fifo_rd) begin
      fifo_empty = 1'b1;
      return;
    end
    data_in = d; stp_in = v.stp; sdp_in = v.sdp; end_in = v.endm;
    valid_in = v.vld; length_in = v.len;
    fifo_empty = 1'b1;
    @(negedge pclk);
    clear_inputs();
    check("fifo_rd_one_cycle", fifo_rd, 1'b0);
    @(negedge pclk);
    // Two cycles after fifo_rd the routed word must be presented.
    check("tlp_valid", tlp_valid, v.tlp);
    check("dllp_valid", dllp_valid, v.dllp);
    if (v.tlp) begin
      check("tlp_sop", tlp_sop, v.sop);
      check("tlp_eop", tlp_eop, v.eop);
      check("tlp_err", tlp_err, v.err);
      check("tlp_be", tlp_be, v.vld);
      check("tlp_len", tlp_len, v.elen);
      check("tlp_data", tlp_data, d);
    end
    if (v.dllp) begin
      check("dllp_be", dllp_be, v.vld);
      check("dllp_data", dllp_data, d);
    end
    if (!v.tlp && !v.dllp && v.vld != '0) exp_drop++;
    check_drops("drop_cnt");
    if (v.tlp || v.dllp) begin
      if (v.hold > 0) begin
        fifo_empty = 1'b0;
        for (int k = 0; k < v.hold; k++) begin
          @(negedge pclk);
          check("hold_valid", tlp_valid | dllp_valid, 1'b1);
          check("hold_data", v.tlp ? tlp_data : dllp_data, d);
          check("hold_no_rd", fifo_rd, 1'b0);
          if (v.tlp) check("hold_eop", tlp_eop, v.eop);
        end
        fifo_empty = 1'b1;
        tlp_ready  = 1'b1;
        dllp_ready = 1'b1;
      end
      @(negedge pclk);
      check("valid_dropped", tlp_valid | dllp_valid, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] ones;
    int          t;
    ones = '1;
    reset = 1'b1; fifo_empty = 1'b1; tlp_ready = 1'b1; dllp_ready = 1'b1;
    clear_inputs();
    @(negedge pclk);
    @(negedge pclk);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_tlp_valid", tlp_valid, 1'b0);
    check("rst_dllp_valid", dllp_valid, 1'b0);
    check("rst_tlp_sop", tlp_sop, 1'b0);
    check("rst_tlp_len", tlp_len, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    @(negedge pclk);

    //           stp     sdp   end          vld       len     tlp dl sop eop err elen   hold
    tbl.push_back(mk(64'd1, 0, 64'd1 << 63, ones, 80'h40, 1, 0, 1, 1, 0, 80'h40, 0));
    tbl.push_back(mk(0, 64'd1, 64'd1 << 7, 64'hFF, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, ones, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64'd1, 0, ones, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(64'd1, 0, 64'd1, 0, 80'h7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(64'd1, 0, 0, ones, 80'h80, 1, 0, 1, 0, 0, 80'h80, 0));
    tbl.push_back(mk(0, 0, 0, 64'hFFFF, 0, 1, 0, 0, 0, 0, 80'h80, 4));
    tbl.push_back(mk(0, 0, 64'd1 << 3, 64'hF, 0, 1, 0, 0, 1, 0, 80'h80, 0));
    tbl.push_back(mk(64'd1, 0, 0, ones, 80'h20, 1, 0, 1, 0, 0, 80'h20, 0));
    tbl.push_back(mk(64'h20, 0, 0, ones, 0, 1, 0, 0, 1, 1, 80'h20, 0));
    tbl.push_back(mk(0, 0, 0, ones, 0, 0, 0, 0, 0, 0, 0, 0));
    // Nine words without END: the ninth exceeds MAX_WORDS and is aborted.
    tbl.push_back(mk(64'd1, 0, 0, ones, 80'h200, 1, 0, 1, 0, 0, 80'h200, 0));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(0, 0, 0, ones, 0, 1, 0, 0, 0, 0, 80'h200, 0));
    tbl.push_back(mk(0, 0, 0, ones, 0, 1, 0, 0, 1, 1, 80'h200, 0));
    tbl.push_back(mk(64'd1, 0, 64'd1 << 10, ones, 80'h10, 1, 0, 1, 1, 0, 80'h10, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset while a first TLP beat is held; the packet must not continue afterwards.
    tlp_ready = 1'b0;
    fifo_empty = 1'b0;
    t = 0;
    while (!fifo_rd && t < 10) begin
      @(negedge pclk);
      t++;
    end
    check("rst_seq_rd", fifo_rd, 1'b1);
    data_in = {8{64'hABCD}}; stp_in = 64'd1; valid_in = ones; length_in = 80'h55;
    fifo_empty = 1'b1;
    @(negedge pclk);
    clear_inputs();
    @(negedge pclk);
    check("rst_seq_beat1", tlp_valid, 1'b1);
    check("rst_seq_sop", tlp_sop, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_tlp_valid", tlp_valid, 1'b0);
    check("async_tlp_sop", tlp_sop, 1'b0);
    check("async_tlp_data", tlp_data, 0);
    check("async_tlp_len", tlp_len, 0);
    check("async_fifo_rd", fifo_rd, 1'b0);
    check("async_drop_cnt", drop_cnt, 0);
    @(negedge pclk);
    reset = 1'b0;
    tlp_ready = 1'b1;
    exp_drop = 0;
    @(negedge pclk);
    apply(mk(0, 0, 64'd1, ones, 0, 0, 0, 0, 0, 0, 0, 0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
